// File: rtl/mem_access_stage.sv
// MIPS memory stage with MEM/WB register: byte/half/word loads and stores over a req/ack bus.
// Define MEM_ACCESS_TIMEOUT_EN to add an ack watchdog that aborts stuck transactions and pulses bus_err_w.

module mem_access_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  output logic        be,
  output logic [7:0]  wbyte
);
  logic [2:0] lane_idx;
  logic [2:0] off_ext;

  assign lane_idx = 3'(LANE);
  assign off_ext  = {1'b0, off};

  always_comb begin
    be    = 1'b0;
    wbyte = wd[8*LANE +: 8];
    if (size[1]) begin
      be    = 1'b1;
      wbyte = wd[8*LANE +: 8];
    end else if (size[0]) begin
      // halfword mask 0011 << off, truncated to four lanes
      be    = (lane_idx >= off_ext) && (lane_idx < off_ext + 3'd2);
      wbyte = wd[8*(LANE % 2) +: 8];
    end else begin
      be    = (lane_idx == off_ext);
      wbyte = wd[7:0];
    end
  end
endmodule

module mem_access_stage #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [1:0]        mem_size_m,
  input  logic              mem_unsigned_m,
  input  logic [31:0]       alu_result_lo_m,
  input  logic [31:0]       alu_result_hi_m,
  input  logic [31:0]       write_data_m,
  input  logic              reg_write_m,
  input  logic [1:0]        reg_write_data_sel_m,
  input  logic [4:0]        reg_file_write_addr_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              stall_m,
  output logic              addr_err_m,
  output logic              bus_err_w,
  output logic              reg_write_w,
  output logic [1:0]        reg_write_data_sel_w,
  output logic [31:0]       data_mem_read_data_w,
  output logic [31:0]       alu_result_hi_w,
  output logic [31:0]       alu_result_lo_w,
  output logic [4:0]        reg_file_write_addr_w
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  sel;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  waddr;
  } wb_t;

  state_t           state;
  wb_t              wb_q;
  logic [1:0]       off;
  logic             is_half, is_word, mem_acc, mem_op, tmo;
  logic [3:0]       be_raw;
  logic [3:0][7:0]  wdata_raw;
  logic [31:0]      shifted, load_data;

  assign off     = alu_result_lo_m[1:0];
  assign is_word = mem_size_m[1];
  assign is_half = (mem_size_m == 2'b01);
  assign mem_acc = valid_m & (mem_read_m | mem_write_m);

  assign addr_err_m = mem_acc & ((is_half & off[0]) | (is_word & (off != 2'b00)));
  assign mem_op     = mem_acc & ~addr_err_m;

  // request drops combinationally in reset so a pending transaction is abandoned at once
  assign dmem_req = rst_n & (((state == IDLE) & mem_op) | ((state == WAIT) & ~tmo));
  assign stall_m  = dmem_req & ~dmem_ack;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    mem_access_lane #(.LANE(i)) u_lane (
      .size  (mem_size_m),
      .off   (off),
      .wd    (write_data_m),
      .be    (be_raw[i]),
      .wbyte (wdata_raw[i])
    );
  end

  assign dmem_we    = dmem_req & mem_write_m;
  assign dmem_addr  = dmem_req ? ADDR_W'({alu_result_lo_m[31:2], 2'b00}) : '0;
  assign dmem_be    = dmem_req ? (mem_write_m ? be_raw : 4'hF) : 4'h0;
  assign dmem_wdata = dmem_we ? wdata_raw : 32'h0;

  assign shifted = dmem_rdata >> {off, 3'b000};

  always_comb begin
    load_data = shifted;
    if (!is_word) begin
      if (is_half) load_data = {{16{~mem_unsigned_m & shifted[15]}}, shifted[15:0]};
      else         load_data = {{24{~mem_unsigned_m & shifted[7]}},  shifted[7:0]};
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             bus_err_q;

  assign tmo       = (state == WAIT) & ~dmem_ack & (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err_w = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign tmo            = 1'b0;
  assign bus_err_w      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (dmem_req & ~dmem_ack) state <= WAIT;
        WAIT:    if (dmem_ack | tmo)       state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
      bus_err_q <= tmo;
      if (state == WAIT && !dmem_ack && !tmo) tmo_cnt <= tmo_cnt + 1'b1;
      else                                    tmo_cnt <= '0;
`endif
    end
  end

  // a stalled cycle becomes a bubble; an aborted or misaligned access retires without a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      if (stall_m) begin
        wb_q.reg_write <= 1'b0;
      end else begin
        wb_q.reg_write <= reg_write_m & valid_m & ~addr_err_m & ~tmo;
        wb_q.sel       <= reg_write_data_sel_m;
        wb_q.hi        <= alu_result_hi_m;
        wb_q.lo        <= alu_result_lo_m;
        wb_q.waddr     <= reg_file_write_addr_m;
      end
      if (dmem_req & dmem_ack & ~mem_write_m) wb_q.rdata <= load_data;
    end
  end

  assign reg_write_w           = wb_q.reg_write;
  assign reg_write_data_sel_w  = wb_q.sel;
  assign data_mem_read_data_w  = wb_q.rdata;
  assign alu_result_hi_w       = wb_q.hi;
  assign alu_result_lo_w       = wb_q.lo;
  assign reg_file_write_addr_w = wb_q.waddr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expected W/bus records, monitors pop and compare.

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_m, mem_read_m, mem_write_m, mem_unsigned_m;
  logic [1:0]  mem_size_m, reg_write_data_sel_m;
  logic [31:0] alu_result_lo_m, alu_result_hi_m, write_data_m;
  logic        reg_write_m;
  logic [4:0]  reg_file_write_addr_m;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_m, addr_err_m, bus_err_w, reg_write_w;
  logic [1:0]  reg_write_data_sel_w;
  logic [31:0] data_mem_read_data_w, alu_result_hi_w, alu_result_lo_w;
  logic [4:0]  reg_file_write_addr_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  wa;
    logic [1:0]  sel;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wd;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .mem_read_m(mem_read_m),
    .mem_write_m(mem_write_m), .mem_size_m(mem_size_m), .mem_unsigned_m(mem_unsigned_m),
    .alu_result_lo_m(alu_result_lo_m), .alu_result_hi_m(alu_result_hi_m),
    .write_data_m(write_data_m), .reg_write_m(reg_write_m),
    .reg_write_data_sel_m(reg_write_data_sel_m), .reg_file_write_addr_m(reg_file_write_addr_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m), .addr_err_m(addr_err_m), .bus_err_w(bus_err_w),
    .reg_write_w(reg_write_w), .reg_write_data_sel_w(reg_write_data_sel_w),
    .data_mem_read_data_w(data_mem_read_data_w), .alu_result_hi_w(alu_result_hi_w),
    .alu_result_lo_w(alu_result_lo_w), .reg_file_write_addr_w(reg_file_write_addr_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && reg_write_w) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", 32'(reg_write_w), 32'd0);
      end else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        chk("wb_waddr", 32'(reg_file_write_addr_w), 32'(e.wa));
        chk("wb_sel",   32'(reg_write_data_sel_w),  32'(e.sel));
        chk("wb_lo",    alu_result_lo_w, e.lo);
        chk("wb_hi",    alu_result_hi_w, e.hi);
        if (e.sel == 2'd1) chk("wb_load_data", data_mem_read_data_w, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (dmem_req && dmem_ack) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 32'(dmem_req), 32'd0);
      end else begin
        bus_exp_t b;
        b = bus_q.pop_front();
        chk("bus_we",   32'(dmem_we), 32'(b.we));
        chk("bus_addr", dmem_addr, b.addr);
        chk("bus_be",   32'(dmem_be), 32'(b.be));
        if (b.chk_wd) chk("bus_wdata", dmem_wdata, b.wdata);
      end
    end
  end

  task automatic idle();
    valid_m = 0; mem_read_m = 0; mem_write_m = 0; mem_size_m = 0; mem_unsigned_m = 0;
    alu_result_lo_m = 0; alu_result_hi_m = 0; write_data_m = 0; reg_write_m = 0;
    reg_write_data_sel_m = 0; reg_file_write_addr_m = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic push_wb(input logic [4:0] wa, input logic [1:0] sel,
                         input logic [31:0] lo, hi, data);
    wb_exp_t e;
    e.wa = wa; e.sel = sel; e.lo = lo; e.hi = hi; e.data = data;
    wb_q.push_back(e);
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic chk_wd);
    bus_exp_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wd; b.chk_wd = chk_wd;
    bus_q.push_back(b);
  endtask

  // Drives one M-stage op; memory acks after wait_n stall cycles. Returns just after the capture edge.
  task automatic run_op(input logic v, rd, wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, wd, hi, input logic rw, input logic [1:0] sel,
                        input logic [4:0] wa, input logic [31:0] rdata, input int wait_n,
                        output int stalls, output int reqs, output logic aerr);
    valid_m = v; mem_read_m = rd; mem_write_m = wr; mem_size_m = sz; mem_unsigned_m = uns;
    alu_result_lo_m = addr; alu_result_hi_m = hi; write_data_m = wd; reg_write_m = rw;
    reg_write_data_sel_m = sel; reg_file_write_addr_m = wa; dmem_rdata = rdata;
    dmem_ack = (wait_n == 0);
    stalls = 0; reqs = 0; aerr = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k == 0) aerr = addr_err_m;
      if (dmem_req) reqs++;
      if (!stall_m) break;
      stalls++;
      @(posedge clk); #1;
      if (stalls >= wait_n) dmem_ack = 1'b1;
    end
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    int st, rq;
    logic ae;
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, rq;
    logic ae;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_reg_write_w", 32'(reg_write_w), 32'd0);
    chk("rst_lo_w",        alu_result_lo_w, 32'd0);
    chk("rst_hi_w",        alu_result_hi_w, 32'd0);
    chk("rst_data_w",      data_mem_read_data_w, 32'd0);
    chk("rst_waddr_w",     32'(reg_file_write_addr_w), 32'd0);
    chk("rst_bus_err_w",   32'(bus_err_w), 32'd0);
    chk("rst_dmem_req",    32'(dmem_req), 32'd0);
    chk("rst_stall",       32'(stall_m), 32'd0);
    @(posedge clk); #1;

    // ALU op, no memory traffic
    push_wb(5'd5, 2'd0, 32'h1234, 32'hAA, 32'h0);
    run_op(1, 0, 0, 2'b10, 0, 32'h1234, 32'h0, 32'hAA, 1, 2'd0, 5'd5, 32'h0, 0, st, rq, ae);
    chk("alu_stalls", 32'(st), 32'd0);
    chk("alu_reqs",   32'(rq), 32'd0);

    // signed byte load at 0x103, ack after 3 stall cycles
    push_bus(0, 32'h100, 4'hF, 32'h0, 0);
    push_wb(5'd8, 2'd1, 32'h103, 32'h0, 32'hFFFFFF80);
    run_op(1, 1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h0, 1, 2'd1, 5'd8, 32'h80FFFFFF, 3, st, rq, ae);
    chk("lb_stalls", 32'(st), 32'd3);
    chk("lb_reqs",   32'(rq), 32'd4);

    // store half 0xABCD at 0x202, zero-wait
    push_bus(1, 32'h200, 4'b1100, 32'hABCDABCD, 1);
    run_op(1, 0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'h0, 0, 2'd0, 5'd0, 32'h0, 0, st, rq, ae);
    chk("sh_stalls", 32'(st), 32'd0);
    chk("sh_reqs",   32'(rq), 32'd1);

    // misaligned word load at 0x006
    run_op(1, 1, 0, 2'b10, 0, 32'h006, 32'h0, 32'h0, 1, 2'd1, 5'd9, 32'h0, 0, st, rq, ae);
    chk("mis_addr_err",   32'(ae), 32'd1);
    chk("mis_reqs",       32'(rq), 32'd0);
    chk("mis_reg_write_w", 32'(reg_write_w), 32'd0);
    chk("mis_lo_w",       alu_result_lo_w, 32'h006);

    // misaligned half store at 0x101
    run_op(1, 0, 1, 2'b01, 0, 32'h101, 32'h5555, 32'h0, 0, 2'd0, 5'd0, 32'h0, 0, st, rq, ae);
    chk("mis_sh_addr_err", 32'(ae), 32'd1);
    chk("mis_sh_reqs",     32'(rq), 32'd0);

    // invalid slot carrying a misaligned load: no error, no request, no write
    run_op(0, 1, 0, 2'b10, 0, 32'h006, 32'h0, 32'h0, 1, 2'd1, 5'd4, 32'h0, 0, st, rq, ae);
    chk("inv_addr_err", 32'(ae), 32'd0);
    chk("inv_reqs",     32'(rq), 32'd0);

    // load alignment/extension table
    push_bus(0, 32'h100, 4'hF, 32'h0, 0);
    push_wb(5'd10, 2'd1, 32'h102, 32'h0, 32'h000080FF);
    run_op(1, 1, 0, 2'b01, 1, 32'h102, 32'h0, 32'h0, 1, 2'd1, 5'd10, 32'h80FFFFFF, 1, st, rq, ae);
    chk("lhu_stalls", 32'(st), 32'd1);

    push_bus(0, 32'h100, 4'hF, 32'h0, 0);
    push_wb(5'd11, 2'd1, 32'h100, 32'h0, 32'hFFFF8765);
    run_op(1, 1, 0, 2'b01, 0, 32'h100, 32'h0, 32'h0, 1, 2'd1, 5'd11, 32'h12348765, 0, st, rq, ae);

    push_bus(0, 32'h100, 4'hF, 32'h0, 0);
    push_wb(5'd12, 2'd1, 32'h101, 32'h0, 32'h00000087);
    run_op(1, 1, 0, 2'b00, 1, 32'h101, 32'h0, 32'h0, 1, 2'd1, 5'd12, 32'h12348765, 2, st, rq, ae);
    chk("lbu_stalls", 32'(st), 32'd2);

    push_bus(0, 32'h104, 4'hF, 32'h0, 0);
    push_wb(5'd13, 2'd1, 32'h104, 32'h0, 32'hDEADBEEF);
    run_op(1, 1, 0, 2'b10, 0, 32'h104, 32'h0, 32'h0, 1, 2'd1, 5'd13, 32'hDEADBEEF, 0, st, rq, ae);

    push_bus(0, 32'h108, 4'hF, 32'h0, 0);
    push_wb(5'd14, 2'd1, 32'h108, 32'h0, 32'h0BADF00D);
    run_op(1, 1, 0, 2'b11, 0, 32'h108, 32'h0, 32'h0, 1, 2'd1, 5'd14, 32'h0BADF00D, 0, st, rq, ae);

    // store byte and word
    push_bus(1, 32'h0, 4'b1000, 32'h5A5A5A5A, 1);
    run_op(1, 0, 1, 2'b00, 0, 32'h003, 32'h1234565A, 32'h0, 0, 2'd0, 5'd0, 32'h0, 0, st, rq, ae);

    push_bus(1, 32'h10, 4'hF, 32'hCAFEF00D, 1);
    run_op(1, 0, 1, 2'b10, 0, 32'h010, 32'hCAFEF00D, 32'h0, 0, 2'd0, 5'd0, 32'h0, 2, st, rq, ae);
    chk("sw_stalls", 32'(st), 32'd2);

    // HI select
    push_wb(5'd31, 2'd2, 32'h777, 32'h99, 32'h0);
    run_op(1, 0, 0, 2'b10, 0, 32'h777, 32'h0, 32'h99, 1, 2'd2, 5'd31, 32'h0, 0, st, rq, ae);

    // reset while waiting for ack
    valid_m = 1; mem_read_m = 1; mem_size_m = 2'b10; alu_result_lo_m = 32'h40;
    reg_write_m = 1; reg_write_data_sel_m = 2'd1; reg_file_write_addr_m = 5'd3; dmem_ack = 0;
    @(negedge clk);
    chk("rstw_stall_idle", 32'(stall_m), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_stall_wait", 32'(stall_m), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_dmem_req",    32'(dmem_req), 32'd0);
    chk("rstw_stall",       32'(stall_m), 32'd0);
    chk("rstw_reg_write_w", 32'(reg_write_w), 32'd0);
    chk("rstw_lo_w",        alu_result_lo_w, 32'd0);
    chk("rstw_hi_w",        alu_result_hi_w, 32'd0);
    chk("rstw_data_w",      data_mem_read_data_w, 32'd0);
    chk("rstw_waddr_w",     32'(reg_file_write_addr_w), 32'd0);
    idle();
    @(posedge clk); #1 rst_n = 1'b1;

    // recovery: zero-wait load straight from IDLE
    push_bus(0, 32'h20, 4'hF, 32'h0, 0);
    push_wb(5'd7, 2'd1, 32'h20, 32'h0, 32'h11223344);
    run_op(1, 1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 1, 2'd1, 5'd7, 32'h11223344, 0, st, rq, ae);
    chk("rec_stalls", 32'(st), 32'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    // no ack ever: 16 WAIT cycles then abort
    run_op(1, 1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h0, 1, 2'd1, 5'd6, 32'h0, 1000, st, rq, ae);
    chk("tmo_stalls",      32'(st), 32'd16);
    chk("tmo_reqs",        32'(rq), 32'd16);
    chk("tmo_bus_err",     32'(bus_err_w), 32'd1);
    chk("tmo_reg_write_w", 32'(reg_write_w), 32'd0);
    @(posedge clk); #1;
    chk("tmo_bus_err_pulse", 32'(bus_err_w), 32'd0);
    chk("tmo_stall_release", 32'(stall_m), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("wb_queue_drained",  32'(wb_q.size()), 32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MIPS pipeline memory stage plus the MEM/WB pipeline register.
- Takes EX/MEM results, performs byte/half/word loads and stores over a req/ack data-memory bus, and aligns and extends load data.
- Registers everything the write-back mux needs.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- TIMEOUT_CYCLES, 16, ack watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_m  in  1  M-stage holds a real instruction.
- mem_read_m  in  1  load.
- mem_write_m  in  1  store.
- mem_size_m  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- mem_unsigned_m  in  1  zero-extend loads when 1; sign-extend when 0.
- alu_result_lo_m  in  32  effective address / ALU low result.
- alu_result_hi_m  in  32  ALU HI result.
- write_data_m  in  32  store data (rt).
- reg_write_m  in  1  destination register write enable.
- reg_write_data_sel_m  in  2  write-back mux select: 0 = lo, 1 = mem, 2 = hi.
- reg_file_write_addr_m  in  5  destination register.
- dmem_req  out  1  transaction request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  transaction complete; rdata valid in the same cycle.
- dmem_rdata  in  32  raw read word.
- stall_m  out  1  hold IF/ID/EX/M registers.
- addr_err_m  out  1  misaligned access detected, combinational.
- bus_err_w  out  1  registered timeout pulse (optional feature).
- reg_write_w  out  1  registered write enable to W.
- reg_write_data_sel_w  out  2  registered mux select.
- data_mem_read_data_w  out  32  registered aligned/extended load data.
- alu_result_hi_w  out  32  registered.
- alu_result_lo_w  out  32  registered.
- reg_file_write_addr_w  out  5  registered destination.

Behaviour:
- Reset (async, rst_n = 0): state = IDLE, all _w outputs 0, bus_err_w 0, timeout counter 0. Combinational outputs settle to 0 while valid_m = 0.
- mem_op = valid_m & (mem_read_m | mem_write_m) & ~addr_err_m.
- Misalignment: addr_err_m = valid_m & (mem_read_m | mem_write_m) & ((half & addr[0]) | (word & addr[1:0] != 0)).
  - A misaligned access issues no request.
  - It is captured in W with reg_write_w = 0.
- FSM states: IDLE, WAIT.
  - dmem_req = (IDLE & mem_op) | WAIT.
  - IDLE -> WAIT when dmem_req & ~dmem_ack.
  - WAIT -> IDLE on dmem_ack.
  - Zero-wait memory (ack in the request cycle) never enters WAIT.
- stall_m = dmem_req & ~dmem_ack. Upstream holds all _m inputs stable while stall_m = 1.
- W register update each cycle:
  - stall_m = 1: insert a bubble. reg_write_w <= 0; other _w fields hold.
  - Otherwise: capture all _m fields. reg_write_w <= reg_write_m & valid_m & ~addr_err_m.
- Non-memory instruction latency: 1 cycle M -> W.
- Memory instruction latency: 1 cycle after the ack cycle.
- Store lanes, with off = addr[1:0]:
  - byte: be = 1 << off; wdata = {4{wd[7:0]}}.
  - half: be = 0011 << off; wdata = {2{wd[15:0]}}.
  - word: be = 1111; wdata = wd.
  - Loads: be = 1111, we = 0.
- Load alignment (little-endian): shift = dmem_rdata >> (8 × off), then extend the byte or half per mem_unsigned_m.
  - data_mem_read_data_w is loaded only on ack. Otherwise it holds its value.
- Reset mid-transaction: returns to IDLE immediately and drops dmem_req. The memory discards the pending request.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - A counter increments each WAIT cycle and clears in IDLE.
  - When it reaches TIMEOUT_CYCLES without ack: force IDLE, deassert dmem_req, release the stall.
  - Capture the instruction with reg_write_w = 0 and pulse bus_err_w for 1 cycle.
- Undefined:
  - No counter. WAIT persists until ack.
  - bus_err_w is tied to 0.

Test Plan:
- ALU op: lo = 0x1234, reg_write_m = 1, addr 5 -> next cycle reg_write_w = 1, alu_result_lo_w = 0x1234, reg_file_write_addr_w = 5, dmem_req never high.
- Signed byte load at addr 0x103, rdata 0x80FFFFFF, ack after 3 cycles -> stall_m high for 3 cycles with bubbles in W, then data_mem_read_data_w = 0xFFFFFF80.
- Store half 0xABCD at addr 0x202 -> dmem_be = 1100, dmem_wdata = 0xABCDABCD, dmem_addr = 0x200, dmem_we = 1, zero-wait ack, no stall.
- Word load at addr 0x006 -> addr_err_m = 1, dmem_req = 0, reg_write_w = 0 next cycle.
- rst_n asserted during WAIT -> dmem_req and stall_m drop immediately; all _w outputs = 0.
- With MEM_ACCESS_TIMEOUT_EN and no ack -> after 16 WAIT cycles bus_err_w pulses once, stall_m releases, reg_write_w = 0.
